// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
// FSM encoding gains a PARITY state only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned CLKS_PER_BIT_DEF = 434;
  localparam int unsigned DATA_BITS_DEF    = 8;
  localparam int unsigned STATE_W          = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of an asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames (8E1 with UART_RX_PARITY_EN), mid-bit sampling,
// one-byte holding register with valid/ack handshake and sticky overrun.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Rx,
  input  logic                 RxAck,
  output logic [DATA_BITS-1:0] Message_in,
  output logic                 RxValid,
  output logic                 RxDone,
  output logic                 Overrun,
  output logic                 FrameErr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 ParityErr
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  uart_state_e          state, state_next;
  logic                 rx_sync, rx_prev;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift;

  logic fall_c, half_tick_c, bit_tick_c, last_bit_c;
  logic cnt_clear_c, start_edge_c, shift_en_c, stop_sample_c, frame_good_c, ack_c;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clock),
    .reset (reset),
    .d     (Rx),
    .q     (rx_sync)
  );

  assign fall_c      = rx_prev & ~rx_sync;
  assign half_tick_c = (cnt == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign bit_tick_c  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit_c  = (bit_cnt == BIT_W'(DATA_BITS - 1));
  assign ack_c       = RxAck & RxValid;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (fall_c) state_next = ST_START;
      ST_START: if (half_tick_c) state_next = rx_sync ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (bit_tick_c && last_bit_c) state_next = ST_PARITY;
      ST_PARITY: if (bit_tick_c) state_next = ST_STOP;
`else
      ST_DATA:  if (bit_tick_c && last_bit_c) state_next = ST_STOP;
`endif
      ST_STOP:  if (bit_tick_c) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic parity_sample_c;
  logic parity_bad;
`endif

  // Per-state control strobes
  always_comb begin
    cnt_clear_c   = 1'b0;
    start_edge_c  = 1'b0;
    shift_en_c    = 1'b0;
    stop_sample_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_sample_c = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        cnt_clear_c  = 1'b1;
        start_edge_c = fall_c;
      end
      ST_START: cnt_clear_c = half_tick_c;
      ST_DATA: begin
        cnt_clear_c = bit_tick_c;
        shift_en_c  = bit_tick_c;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        cnt_clear_c     = bit_tick_c;
        parity_sample_c = bit_tick_c;
      end
`endif
      ST_STOP: begin
        cnt_clear_c   = bit_tick_c;
        stop_sample_c = bit_tick_c;
      end
      default: cnt_clear_c = 1'b1;
    endcase
  end

  // Baud counter, bit counter, shift register and edge history
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_sync;
      cnt     <= cnt_clear_c ? '0 : cnt + CNT_W'(1);
      if (start_edge_c)    bit_cnt <= '0;
      else if (shift_en_c) bit_cnt <= bit_cnt + BIT_W'(1);
      if (shift_en_c) shift <= {rx_sync, shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Even parity: the received parity bit must equal the XOR of the data bits
  always_ff @(posedge clock) begin
    if (reset)                parity_bad <= 1'b0;
    else if (parity_sample_c) parity_bad <= rx_sync ^ (^shift);
  end

  assign frame_good_c = stop_sample_c & rx_sync & ~parity_bad;
`else
  assign frame_good_c = stop_sample_c & rx_sync;
`endif

  // Holding register, handshake and status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      Message_in <= '0;
      RxValid    <= 1'b0;
      RxDone     <= 1'b0;
      Overrun    <= 1'b0;
      FrameErr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      ParityErr  <= 1'b0;
`endif
    end else begin
      RxDone   <= frame_good_c;
      FrameErr <= stop_sample_c & ~rx_sync;
`ifdef UART_RX_PARITY_EN
      ParityErr <= stop_sample_c & parity_bad;
`endif
      if (frame_good_c) begin
        Message_in <= shift;
        RxValid    <= 1'b1;
        if (RxValid && !RxAck) Overrun <= 1'b1;
        else if (ack_c)        Overrun <= 1'b0;
      end else if (ack_c) begin
        RxValid <= 1'b0;
        Overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16. Table of frames plus
// hand-written corner sequences; received bytes are checked via a scoreboard.
module tb_uart_rx;

  localparam int unsigned CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB / 2 + 10 * CPB;
`else
  localparam int LAT = 2 + CPB / 2 + 9 * CPB;
`endif

  logic       clk, reset, Rx, RxAck;
  logic [7:0] Message_in;
  logic       RxValid, RxDone, Overrun, FrameErr;
`ifdef UART_RX_PARITY_EN
  logic       ParityErr;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clock      (clk),
    .reset      (reset),
    .Rx         (Rx),
    .RxAck      (RxAck),
    .Message_in (Message_in),
    .RxValid    (RxValid),
    .RxDone     (RxDone),
    .Overrun    (Overrun),
    .FrameErr   (FrameErr)
`ifdef UART_RX_PARITY_EN
    ,
    .ParityErr  (ParityErr)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  bit lat_armed = 0;
  int done_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       ack_before;
    logic [7:0] exp_msg;
    logic       exp_valid;
    logic       exp_ovr;
    int         exp_done;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pulse counting, scoreboard pop and latency check on each RxDone
  initial forever begin
    @(negedge clk);
    if (FrameErr) fe_cnt++;
`ifdef UART_RX_PARITY_EN
    if (ParityErr) pe_cnt++;
`endif
    if (RxDone) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rxdone actual byte=%0h expected no frame", Message_in);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("rx_byte", 32'(Message_in), 32'(e));
      end
      if (lat_armed) begin
        int d;
        d = cyc - fall_cyc;
        checks++;
        if (d < LAT - 1 || d > LAT + 1) begin
          errors++;
          $display("FAIL latency actual=%0d required=%0d+-1", d, LAT);
        end
        lat_armed = 0;
      end
    end
  end

  task automatic clear_counts();
    done_cnt = 0;
    fe_cnt   = 0;
    pe_cnt   = 0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad);
    @(posedge clk);
    #1 Rx = 1'b0;
    fall_cyc  = cyc + 1;
    lat_armed = 1;
    if (stop_bit && !par_bad) exp_q.push_back(d);
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 Rx = d[i];
      repeat (CPB) @(posedge clk);
    end
`ifdef UART_RX_PARITY_EN
    #1 Rx = (^d) ^ par_bad;
    repeat (CPB) @(posedge clk);
`endif
    #1 Rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1 Rx = 1'b1;
  endtask

  task automatic pulse_ack();
    @(posedge clk);
    #1 RxAck = 1'b1;
    @(posedge clk);
    #1 RxAck = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{8'hA3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0, 1};
    vecs[1] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1, 0};
    vecs[2] = '{8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 1, 0};
    vecs[3] = '{8'h34, 1'b1, 1'b0, 8'h34, 1'b1, 1'b1, 1, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1, 0};

    reset = 1'b1;
    Rx    = 1'b1;
    RxAck = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_msg", 32'(Message_in), 32'h00);
    chk("rst_valid", 32'(RxValid), 32'h0);
    chk("rst_done", 32'(RxDone), 32'h0);
    chk("rst_ovr", 32'(Overrun), 32'h0);
    chk("rst_fe", 32'(FrameErr), 32'h0);
    repeat (4) @(posedge clk);

    // Table-driven frames
    for (int k = 0; k < 7; k++) begin
      if (vecs[k].ack_before) pulse_ack();
      clear_counts();
      send_frame(vecs[k].data, vecs[k].stop_bit, 1'b0);
      settle();
      chk($sformatf("v%0d_msg", k), 32'(Message_in), 32'(vecs[k].exp_msg));
      chk($sformatf("v%0d_valid", k), 32'(RxValid), 32'(vecs[k].exp_valid));
      chk($sformatf("v%0d_ovr", k), 32'(Overrun), 32'(vecs[k].exp_ovr));
      chk($sformatf("v%0d_done", k), 32'(done_cnt), 32'(vecs[k].exp_done));
      chk($sformatf("v%0d_fe", k), 32'(fe_cnt), 32'(vecs[k].exp_fe));
    end

    // Ack clears valid; a second ack with nothing pending is ignored
    pulse_ack();
    @(negedge clk);
    chk("ack_valid", 32'(RxValid), 32'h0);
    chk("ack_ovr", 32'(Overrun), 32'h0);
    pulse_ack();
    @(negedge clk);
    chk("ack_idle_valid", 32'(RxValid), 32'h0);
    chk("ack_idle_msg", 32'(Message_in), 32'h80);

    // Short low glitch: start check rejects it
    clear_counts();
    @(posedge clk);
    #1 Rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 Rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_done", 32'(done_cnt), 32'h0);
    chk("glitch_fe", 32'(fe_cnt), 32'h0);
    chk("glitch_valid", 32'(RxValid), 32'h0);

    // New frame landing in the same cycle as an ack: no overrun
    send_frame(8'h55, 1'b1, 1'b0);
    settle();
    clear_counts();
    fork
      send_frame(8'hC6, 1'b1, 1'b0);
      begin
        repeat (LAT + 1) @(posedge clk);
        #1 RxAck = 1'b1;
        @(posedge clk);
        #1 RxAck = 1'b0;
      end
    join
    settle();
    chk("coinc_msg", 32'(Message_in), 32'hC6);
    chk("coinc_valid", 32'(RxValid), 32'h1);
    chk("coinc_ovr", 32'(Overrun), 32'h0);
    chk("coinc_done", 32'(done_cnt), 32'h1);

    // Reset during data bit 3 of 0xFF, then a clean 0x7E
    clear_counts();
    @(posedge clk);
    #1 Rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 Rx = 1'b1;
    repeat (3 * CPB + CPB / 2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    lat_armed = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midrst_msg", 32'(Message_in), 32'h00);
    chk("midrst_valid", 32'(RxValid), 32'h0);
    chk("midrst_ovr", 32'(Overrun), 32'h0);
    chk("midrst_fe", 32'(fe_cnt), 32'h0);
    chk("midrst_done", 32'(done_cnt), 32'h0);
    send_frame(8'h7E, 1'b1, 1'b0);
    settle();
    chk("post_rst_msg", 32'(Message_in), 32'h7E);
    chk("post_rst_valid", 32'(RxValid), 32'h1);
    chk("post_rst_done", 32'(done_cnt), 32'h1);

`ifdef UART_RX_PARITY_EN
    // Parity error suppresses the load; correct parity loads
    pulse_ack();
    clear_counts();
    send_frame(8'h0F, 1'b1, 1'b1);
    settle();
    chk("par_bad_pe", 32'(pe_cnt), 32'h1);
    chk("par_bad_done", 32'(done_cnt), 32'h0);
    chk("par_bad_valid", 32'(RxValid), 32'h0);
    chk("par_bad_msg", 32'(Message_in), 32'h7E);
    clear_counts();
    send_frame(8'h0F, 1'b1, 1'b0);
    settle();
    chk("par_ok_pe", 32'(pe_cnt), 32'h0);
    chk("par_ok_msg", 32'(Message_in), 32'h0F);
    chk("par_ok_valid", 32'(RxValid), 32'h1);
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
